// File: rtl/booth_seq_pkg.sv
// Shared types and defaults for the booth multiplier sequencer.
package booth_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    RUN,
    CAP_A,
    CAP_Q,
    RESP
  } state_e;

  localparam int DEF_M_CYC   = 1;
  localparam int DEF_Q_CYC   = 1;
  localparam int DEF_A_DLY   = 1;
  localparam int DEF_Q_DLY   = 1;
  localparam int DEF_TIMEOUT = 64;

  localparam int PROD_W = 16;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/cycle_counter.sv
// Free-running wait counter with synchronous clear and a terminal-count flag.
module cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         at_tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign at_tc_o = (cnt_q == tc_i);

endmodule

// File: rtl/booth_seq.sv
// Sequencer around the booth core: loads M/Q over inbus, waits for done,
// collects A/Q bytes from outbus and returns a signed 16-bit product.
module booth_seq
  import booth_seq_pkg::*;
#(
  parameter int M_CYC   = DEF_M_CYC,
  parameter int Q_CYC   = DEF_Q_CYC,
  parameter int A_DLY   = DEF_A_DLY,
  parameter int Q_DLY   = DEF_Q_DLY,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        op_m,
  input  logic [7:0]        op_q,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_product,
  output logic              res_err,
  output logic              booth_enable,
  output logic [7:0]        booth_inbus,
  input  logic              booth_done,
  input  logic [7:0]        booth_outbus
);

  state_e            state_q, state_d;
  logic [7:0]        m_q, q_q, inbus_q;
  logic [PROD_W-1:0] prod_q;
  logic              op_ready_q, res_valid_q, res_err_q, enable_q, done_q;

  logic [CNT_W-1:0]  cnt_tc;
  logic              cnt_at_tc, cnt_en, cnt_clr;
  logic              accept, done_rise;

  assign accept    = op_valid && op_ready_q;
  assign done_rise = booth_done && !done_q;

  // One counter serves every timed state; it restarts on each state change.
  always_comb begin
    cnt_tc = '0;
    cnt_en = 1'b0;
    case (state_q)
      LOAD_M: begin cnt_tc = CNT_W'(M_CYC - 1);   cnt_en = 1'b1; end
      LOAD_Q: begin cnt_tc = CNT_W'(Q_CYC - 1);   cnt_en = 1'b1; end
      RUN:    begin cnt_tc = CNT_W'(TIMEOUT - 1); cnt_en = 1'b1; end
      CAP_A:  begin cnt_tc = CNT_W'(A_DLY - 1);   cnt_en = 1'b1; end
      CAP_Q:  begin cnt_tc = CNT_W'(Q_DLY - 1);   cnt_en = 1'b1; end
      default: ;
    endcase
  end

  assign cnt_clr = (state_d != state_q);

  cycle_counter #(.W(CNT_W)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .tc_i    (cnt_tc),
    .at_tc_o (cnt_at_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = LOAD_M;
      LOAD_M: if (booth_done) state_d = RESP;
              else if (cnt_at_tc) state_d = LOAD_Q;
      LOAD_Q: if (booth_done) state_d = RESP;
              else if (cnt_at_tc) state_d = RUN;
      RUN:    if (done_rise) state_d = CAP_A;
              else if (cnt_at_tc) state_d = RESP;
      CAP_A:  if (cnt_at_tc) state_d = CAP_Q;
      CAP_Q:  if (cnt_at_tc) state_d = RESP;
      RESP:   if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      enable_q    <= 1'b0;
      inbus_q     <= '0;
      m_q         <= '0;
      q_q         <= '0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= booth_done;
      op_ready_q  <= (state_d == IDLE);
      res_valid_q <= (state_d == RESP);
      enable_q    <= accept;

      if (accept) begin
        m_q <= op_m;
        q_q <= op_q;
      end

      case (state_d)
        IDLE:     inbus_q <= '0;
        LOAD_M:   inbus_q <= accept ? op_m : m_q;
        LOAD_Q,
        RUN:      inbus_q <= q_q;
        default: ;
      endcase

      if (state_q == CAP_A && cnt_at_tc) prod_q[15:8] <= booth_outbus;
      if (state_q == CAP_Q && cnt_at_tc) prod_q[7:0]  <= booth_outbus;

      // Reaching RESP from anywhere but CAP_Q means timeout or early done.
      if (state_d == RESP && state_q != RESP && state_q != CAP_Q) begin
        res_err_q <= 1'b1;
        prod_q    <= '0;
      end else if (state_d == IDLE) begin
        res_err_q <= 1'b0;
      end
    end
  end

  assign op_ready     = op_ready_q;
  assign res_valid    = res_valid_q;
  assign res_err      = res_err_q;
  assign res_product  = prod_q;
  assign booth_enable = enable_q;
  assign booth_inbus  = inbus_q;

endmodule
